// File: rtl/aes_key_expand.sv
// AES key-schedule engine: expands a 128/192/256-bit key into Nr+1 round keys,
// one 32-bit schedule word per cycle, with a registered round-key read port.
package aes_const;
  localparam int Nb = 4;
  localparam int Nk = 4;
  localparam int Nr = 10;
  localparam logic [127:0] key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
endpackage

module aes_key_expand #(
  parameter int Nb = aes_const::Nb,
  parameter int Nk = aes_const::Nk,
  parameter int Nr = aes_const::Nr
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            key_valid,
  output logic            key_ready,
  input  logic [32*Nk-1:0] key_in,
  output logic            done,
  input  logic [3:0]      rk_addr,
  output logic [127:0]    rk_data
);

  localparam int W  = Nb * (Nr + 1);
  localparam int IW = $clog2(W + 1);
  localparam logic [IW-1:0] NK_I   = IW'(Nk);
  localparam logic [IW-1:0] LAST_I = IW'(W - 1);
  localparam logic [2:0]    KC_LAST = 3'(Nk - 1);
  localparam logic [3:0]    NR_A   = 4'(Nr);

  if (Nb != 4 || !((Nk == 4 && Nr == 10) || (Nk == 6 && Nr == 12) || (Nk == 8 && Nr == 14)))
  begin : g_bad_cfg
    $error("aes_key_expand: unsupported Nb/Nk/Nr combination");
  end

  // Byte 0x00 sits in the MSBs, so sbox(b) is entry 255-b, i.e. SBOX[~b].
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[~x[31:24]], SBOX[~x[23:16]], SBOX[~x[15:8]], SBOX[~x[7:0]]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t         state, state_nxt;
  logic [31:0]    w [W];
  logic [IW-1:0]  i;
  logic [2:0]     kcnt;
  logic [7:0]     rcon;
  logic           accept;
  logic [31:0]    prev, sub_in, sub_out, temp, new_word;

  always_comb begin
    state_nxt = state;
    key_ready = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) state_nxt = EXPAND;
      end
      EXPAND: if (i == LAST_I) state_nxt = DONE;
      DONE: begin
        key_ready = 1'b1;
        done      = 1'b1;
        if (key_valid) state_nxt = EXPAND;
      end
      default: state_nxt = IDLE;
    endcase
    accept = key_valid & key_ready;
  end

  always_comb begin
    prev    = w[i - 1'b1];
    sub_in  = (kcnt == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    sub_out = sub_word(sub_in);
    if (kcnt == 3'd0)
      temp = sub_out ^ {rcon, 24'h0};
    else if (Nk == 8 && kcnt == 3'd4)
      temp = sub_out;
    else
      temp = prev;
    new_word = w[i - NK_I] ^ temp;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      w     <= '{default: '0};
      i     <= '0;
      kcnt  <= '0;
      rcon  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        for (int unsigned k = 0; k < Nk; k++)
          w[k[IW-1:0]] <= key_in[32*(Nk-1-k) +: 32];
        i    <= NK_I;
        kcnt <= '0;
        rcon <= 8'h01;
      end else if (state == EXPAND) begin
        w[i] <= new_word;
        i    <= i + 1'b1;
        kcnt <= (kcnt == KC_LAST) ? '0 : kcnt + 3'd1;
        if (kcnt == 3'd0) rcon <= xtime(rcon);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      rk_data <= '0;
    else if (rk_addr <= NR_A)
      rk_data <= {w[IW'({rk_addr, 2'd0})], w[IW'({rk_addr, 2'd1})],
                  w[IW'({rk_addr, 2'd2})], w[IW'({rk_addr, 2'd3})]};
    else
      rk_data <= '0;
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: three instances (AES-128/192/256) checked every cycle
// against a FIPS-197 style key-schedule model, plus literal known-answer checks.
module tb_aes_key_expand;

  localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  logic         kv  [3];
  logic [255:0] kin [3];
  logic         kr  [3];
  logic         dn  [3];
  logic [3:0]   ra  [3];
  logic [127:0] rd  [3];

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_on = 1'b0;
  logic [7:0] sb [256];

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  function automatic void expand_key(input int nk, input logic [255:0] k, output logic [31:0] s [60]);
    logic [31:0] t;
    logic [7:0]  rc;
    for (int j = 0; j < 60; j++) s[j] = '0;
    for (int j = 0; j < nk; j++) s[j] = k[32*(nk-j)-1 -: 32];
    for (int j = nk; j < 4 * (nk + 7); j++) begin
      t = s[j-1];
      if (j % nk == 0) begin
        rc = 8'h01;
        for (int r = 1; r < j / nk; r++) rc = gmul(rc, 8'h02);
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
      end else if (nk == 8 && j % nk == 4) begin
        t = subw(t);
      end
      s[j] = s[j-nk] ^ t;
    end
  endfunction

  for (genvar G = 0; G < 3; G++) begin : g_inst
    localparam int NK = 4 + 2 * G;
    localparam int NR = NK + 6;
    localparam int W  = 4 * (NR + 1);

    logic [31:0]  arr [60];
    logic [31:0]  sched [60];
    logic [127:0] exp_rd;
    logic         exp_kr, exp_dn;

    aes_key_expand #(.Nb(4), .Nk(NK), .Nr(NR)) dut (
      .clock    (clock),
      .reset    (rst_n),
      .key_valid(kv[G]),
      .key_ready(kr[G]),
      .key_in   (kin[G][32*NK-1:0]),
      .done     (dn[G]),
      .rk_addr  (ra[G]),
      .rk_data  (rd[G])
    );

    // phase: 0 waiting for a key, 1 expanding, 2 schedule complete
    initial begin : model
      int phase, cyc, a;
      phase = 0; cyc = 0; exp_rd = '0;
      for (int j = 0; j < 60; j++) begin arr[j] = '0; sched[j] = '0; end
      exp_kr = 1'b1; exp_dn = 1'b0;
      forever begin
        @(posedge clock or negedge rst_n);
        if (!rst_n) begin
          phase = 0; cyc = 0; exp_rd = '0;
          for (int j = 0; j < 60; j++) arr[j] = '0;
        end else begin
          a = int'(ra[G]);
          exp_rd = (a <= NR) ? {arr[4*a], arr[4*a+1], arr[4*a+2], arr[4*a+3]} : '0;
          if (phase == 1) begin
            cyc++;
            arr[NK+cyc-1] = sched[NK+cyc-1];
            if (NK + cyc == W) phase = 2;
          end else if (kv[G]) begin
            expand_key(NK, kin[G], sched);
            for (int j = 0; j < NK; j++) arr[j] = sched[j];
            cyc = 0;
            phase = 1;
          end
        end
        exp_kr = (phase != 1);
        exp_dn = (phase == 2);
      end
    end

    initial begin : compare
      forever begin
        @(negedge clock);
        if (chk_on) begin
          chk($sformatf("key_ready[%0d]", G), kr[G], exp_kr);
          chk($sformatf("done[%0d]", G), dn[G], exp_dn);
          chk($sformatf("rk_data[%0d]", G), rd[G], exp_rd);
        end
      end
    end
  end

  function automatic logic [255:0] rkey();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic offer(input logic [255:0] k0, input logic [255:0] k1, input logic [255:0] k2);
    @(negedge clock);
    kin[0] = k0; kin[1] = k1; kin[2] = k2;
    for (int g = 0; g < 3; g++) kv[g] = 1'b1;
    @(negedge clock);
    for (int g = 0; g < 3; g++) kv[g] = 1'b0;
  endtask

  task automatic wait_done(input bit poke, output int c0, output int c1, output int c2);
    c0 = 0; c1 = 0; c2 = 0;
    for (int k = 1; k <= 70; k++) begin
      for (int g = 0; g < 3; g++) ra[g] = 4'($urandom_range(0, 15));
      if (poke) begin
        kv[0] = (k < 20);
        if (k < 20) kin[0] = rkey();
      end
      @(negedge clock);
      if (c0 == 0 && dn[0]) c0 = k;
      if (c1 == 0 && dn[1]) c1 = k;
      if (c2 == 0 && dn[2]) c2 = k;
      if (poke && k == 10) chk("busy_key_ready", kr[0], 1'b0);
    end
    kv[0] = 1'b0;
  endtask

  task automatic read_rk(input int g, input logic [3:0] a, input logic [127:0] e, input string nm);
    ra[g] = a;
    @(negedge clock);
    chk(nm, rd[g], e);
  endtask

  initial begin
    int c0, c1, c2;
    logic [31:0] s [60];
    for (int g = 0; g < 3; g++) begin kv[g] = 1'b0; kin[g] = '0; ra[g] = '0; end
    build_sbox();
    chk("model_sbox_00", sb[0], 8'h63);
    chk("model_sbox_53", sb[8'h53], 8'hed);
    expand_key(4, {128'h0, K128}, s);
    chk("model_w43", s[43], 32'hb6630ca6);

    repeat (3) @(negedge clock);
    #2 rst_n = 1'b1;
    chk_on = 1'b1;
    @(negedge clock);
    chk("reset_key_ready", kr[0], 1'b1);
    chk("reset_done", dn[0], 1'b0);
    chk("reset_rk_data", rd[0], 128'h0);

    offer({128'h0, K128}, {64'h0, K192}, K256);
    wait_done(1'b1, c0, c1, c2);
    chk("done_cycles_128", c0, 40);
    chk("done_cycles_192", c1, 46);
    chk("done_cycles_256", c2, 52);
    read_rk(0, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605, "aes128_rk1");
    read_rk(0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "aes128_rk10");
    read_rk(0, 4'd0,  K128, "aes128_rk0");
    read_rk(0, 4'd11, 128'h0, "aes128_rk11_oob");
    read_rk(1, 4'd12, 128'he98ba06f448c773c8ecc720401002202, "aes192_rk12");
    read_rk(2, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e, "aes256_rk14");

    offer({128'h0, K128}, rkey(), rkey());
    repeat (20) begin
      for (int g = 0; g < 3; g++) ra[g] = 4'($urandom_range(0, 15));
      @(negedge clock);
    end
    #2 rst_n = 1'b0;
    @(negedge clock);
    chk("midreset_done", dn[0], 1'b0);
    #2 rst_n = 1'b1;
    read_rk(0, 4'd10, 128'h0, "midreset_rk10");

    offer({128'h0, K128}, {64'h0, K192}, K256);
    wait_done(1'b0, c0, c1, c2);
    chk("post_reset_cycles", c0, 40);
    read_rk(0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "post_reset_rk10");

    offer('0, rkey(), rkey());
    chk("rekey_done_falls", dn[0], 1'b0);
    wait_done(1'b0, c0, c1, c2);
    chk("rekey_cycles", c0, 40);
    read_rk(0, 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, "zero_key_rk10");
    read_rk(0, 4'd1,  128'h62636363626363636263636362636363, "zero_key_rk1");

    repeat (400) begin
      for (int g = 0; g < 3; g++) begin
        kv[g]  = ($urandom_range(0, 7) == 0);
        kin[g] = rkey();
        ra[g]  = 4'($urandom_range(0, 15));
      end
      @(negedge clock);
    end
    for (int g = 0; g < 3; g++) kv[g] = 1'b0;
    repeat (60) begin
      for (int g = 0; g < 3; g++) ra[g] = 4'($urandom_range(0, 15));
      @(negedge clock);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Sequential AES key-schedule engine that turns a 128/192/256-bit cipher key into the full set of Nr+1 128-bit round keys, producing one 32-bit schedule word per cycle. It sits between the key source and the cipher round datapath. Its parameter defaults come from `aes_const` (Nb, Nk, Nr, and the `key` test constant). The round datapath reads finished round keys through a registered read port.

## Interface
- Nb, 4: words per state; fixed at 4.
- Nk, 4: key length in 32-bit words; 4, 6 or 8.
- Nr, 10: number of rounds; must equal Nk+6. Any other Nk/Nr combination is an elaboration error.

Ports:
- clock  in  1  Single clock; everything samples on the rising edge.
- reset  in  1  Asynchronous, active-low reset.
- key_valid  in  1  Key offer.
- key_ready  out  1  Engine can accept a key.
- key_in  in  32*Nk  Cipher key. w[0] is in the MSBs `[32*Nk-1 -: 32]`.
- done  out  1  Full schedule is valid.
- rk_addr  in  4  Round-key index, 0..Nr.
- rk_data  out  128  Round key rk_addr, as {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in the MSBs.

## Operation
- Storage: 4*(Nr+1) words of 32 bits (W). W = 44, 52 or 60 for AES-128, -192 or -256.
- States:
  - IDLE: key_ready=1, done=0.
  - EXPAND: key_ready=0.
  - DONE: key_ready=1, done=1.
- Transitions:
  - IDLE→EXPAND, or DONE→EXPAND, on key_valid & key_ready. At that edge, w[0..Nk-1] load from key_in, i loads Nk, rcon loads 0x01, and done clears.
  - EXPAND→DONE on the edge that writes w[W-1].
- Per EXPAND cycle:
  - temp = w[i-1].
  - If i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon ← xtime(rcon). xtime is a left shift by 1, XORed with 0x1b when bit 7 was set.
  - Else if Nk==8 and i mod Nk == 4: temp = SubWord(temp).
  - Then w[i] = w[i-Nk] ^ temp, and i increments.
  - SubWord applies the FIPS-197 S-box to each byte. RotWord turns {a,b,c,d} into {b,c,d,a}.
  - The i mod Nk test uses a separate 0..Nk-1 counter, not a divider.
- Key_valid is ignored while key_ready=0, so a new key is never accepted mid-expansion.
- Read port: rk_data is registered from rk_addr every cycle, regardless of state.
  - rk_addr > Nr returns 128'h0.
  - Reads before done are permitted and return whatever the array holds: partially written, or zeros after reset.
- Reset (any time, including mid-EXPAND):
  - state goes to IDLE.
  - The word array, i, rcon and rk_data clear to 0.
  - done=0; key_ready=1 once reset deasserts.

## Timing
- Handshake edge = edge 0. w[Nk+k] is written at edge k+1.
- done rises after edge W-Nk: 40, 46 and 52 cycles for Nk = 4, 6 and 8.
- done stays high until the next accepted key or reset. It falls at the accept edge.
- key_ready is combinational from state (high in IDLE and DONE), with no dependency on key_valid.
- Read latency: rk_addr presented before edge n gives rk_data valid after edge n (one cycle).
- In DONE with key_valid held high, a new expansion starts immediately and done drops the next cycle.

## Test plan
- **AES-128.** Key 2b7e151628aed2a6abf7158809cf4f3c.
  - done is high exactly 40 cycles after the handshake.
  - rk 1 = a0fafe1788542cb123a339392a6c7605.
  - rk 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rk 0 = the key.
- **AES-192** (Nk=6, Nr=12). Key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b.
  - done is high after 46 cycles.
  - rk 12 = e98ba06f448c773c8ecc720401002202.
- **AES-256** (Nk=8, Nr=14). Key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4.
  - done is high after 52 cycles.
  - rk 14 = fe4890d1e6188d0b046df344706c631e. This exercises the i mod 8 == 4 SubWord path.
- **Busy behaviour.**
  - Assert key_valid with a different key during EXPAND: it is ignored, key_ready stays 0, and the result still matches the first key.
  - Read rk_addr=11 on AES-128: rk_data = 0.
- **Reset mid-EXPAND.**
  - Reset at cycle 20: done=0, and rk 10 reads 0.
  - A subsequent AES-128 key still gives rk 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 after 40 cycles.
- **Rekey from DONE.**
  - Offer the all-zero key while in DONE: done falls on the next edge.
  - After 40 cycles, rk 10 = b4ef5bcb3e92e21123e951cf6f8f188e and rk 1 = 62636363626363636263636362636363.
